// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: I-cache and D-cache share one physical memory port.
// Define MEM_ARBITER_RR_EN for round-robin on simultaneous requests (default: D has fixed priority).
module mem_arbiter (
    input  logic         clk,
    input  logic         reset,

    input  logic         i_pmem_read,
    input  logic [15:0]  i_pmem_address,
    output logic         i_pmem_resp,
    output logic [127:0] i_pmem_rdata,

    input  logic         d_pmem_read,
    input  logic         d_pmem_write,
    input  logic [15:0]  d_pmem_address,
    input  logic [127:0] d_pmem_wdata,
    output logic         d_pmem_resp,
    output logic [127:0] d_pmem_rdata,

    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic         pmem_resp,
    input  logic [127:0] pmem_rdata
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

    state_t state;
    state_t next_state;
    logic   d_req;
    logic   pick_i;
    logic   unused_addr_bits;

    assign d_req            = d_pmem_read | d_pmem_write;
    assign unused_addr_bits = ^{i_pmem_address[3:0], d_pmem_address[3:0]};

`ifdef MEM_ARBITER_RR_EN
    // prio_i set means I wins the next tie; flips whenever a grant completes.
    logic prio_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_i <= 1'b0;
        end else if ((state != IDLE) && pmem_resp) begin
            prio_i <= ~prio_i;
        end
    end

    assign pick_i = i_pmem_read & (~d_req | prio_i);
`else
    assign pick_i = i_pmem_read & ~d_req;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A grant ends on response or when the owner withdraws its request.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (pick_i) begin
                    next_state = SERVE_I;
                end else if (d_req) begin
                    next_state = SERVE_D;
                end
            end
            SERVE_I: begin
                if (pmem_resp || !i_pmem_read) begin
                    next_state = IDLE;
                end
            end
            SERVE_D: begin
                if (pmem_resp || !d_req) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Responses are gated by the owner's live request so a withdrawn request never sees resp.
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0000;
        pmem_wdata   = '0;
        i_pmem_resp  = 1'b0;
        i_pmem_rdata = '0;
        d_pmem_resp  = 1'b0;
        d_pmem_rdata = '0;
        unique case (state)
            SERVE_I: begin
                pmem_read    = i_pmem_read;
                pmem_address = {i_pmem_address[15:4], 4'b0000};
                i_pmem_resp  = pmem_resp & i_pmem_read;
                i_pmem_rdata = pmem_rdata;
            end
            SERVE_D: begin
                pmem_write   = d_pmem_write;
                pmem_read    = d_pmem_read & ~d_pmem_write;
                pmem_address = {d_pmem_address[15:4], 4'b0000};
                pmem_wdata   = d_pmem_wdata;
                d_pmem_resp  = pmem_resp & d_req;
                d_pmem_rdata = pmem_rdata;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; expectations are hand-computed.
// Honours MEM_ARBITER_RR_EN for the tie-break expectation.
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_pmem_read;
    logic [15:0]  i_pmem_address;
    logic         i_pmem_resp;
    logic [127:0] i_pmem_rdata;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [15:0]  d_pmem_address;
    logic [127:0] d_pmem_wdata;
    logic         d_pmem_resp;
    logic [127:0] d_pmem_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] DATA_A5 = {16{8'hA5}};
    localparam logic [127:0] DATA_5C = {16{8'h5C}};
    localparam logic [127:0] DATA_WB = 128'h0123456789ABCDEF0123456789ABCDEF;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_resp    (i_pmem_resp),
        .i_pmem_rdata   (i_pmem_rdata),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_resp    (d_pmem_resp),
        .d_pmem_rdata   (d_pmem_rdata),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_resp      (pmem_resp),
        .pmem_rdata     (pmem_rdata)
    );

    // Inputs change just after the falling edge; outputs are sampled 1ns later.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        i_pmem_read    = 1'b0;
        i_pmem_address = 16'h0000;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        d_pmem_address = 16'h0000;
        d_pmem_wdata   = '0;
        pmem_resp      = 1'b0;
        pmem_rdata     = '0;
    endtask

    task automatic do_reset();
        step();
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0000) begin
            $display("[TB] FAIL reset_ctrl: got %b expected 0000", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp});
            failures++;
        end
        checks++;
        if ({pmem_address, pmem_wdata, i_pmem_rdata, d_pmem_rdata} !== '0) begin
            $display("[TB] FAIL reset_data: address/data outputs not zero, pmem_address=%h", pmem_address);
            failures++;
        end
    endtask

    task automatic test_lone_i();
        do_reset();
        step();
        i_pmem_read    = 1'b1;
        i_pmem_address = 16'h1236;
        #1;
        checks++;
        if (pmem_read !== 1'b0) begin
            $display("[TB] FAIL lone_i_latency: pmem_read=%b expected 0 before grant edge", pmem_read);
            failures++;
        end
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 4) begin
                pmem_resp  = 1'b1;
                pmem_rdata = DATA_A5;
            end
            #1;
            checks++;
            if ({pmem_read, pmem_write, pmem_address} !== {1'b1, 1'b0, 16'h1230}) begin
                $display("[TB] FAIL lone_i_grant c%0d: rd=%b wr=%b addr=%h expected rd=1 wr=0 addr=1230", c, pmem_read, pmem_write, pmem_address);
                failures++;
            end
            checks++;
            if ({i_pmem_resp, d_pmem_resp} !== {(c == 4), 1'b0}) begin
                $display("[TB] FAIL lone_i_resp c%0d: i_resp=%b d_resp=%b expected %b 0", c, i_pmem_resp, d_pmem_resp, (c == 4));
                failures++;
            end
        end
        checks++;
        if (i_pmem_rdata !== DATA_A5 || d_pmem_rdata !== '0) begin
            $display("[TB] FAIL lone_i_rdata: i_rdata=%h d_rdata=%h expected a5.. and 0", i_pmem_rdata, d_pmem_rdata);
            failures++;
        end
        step();
        clear_inputs();
        #1;
        checks++;
        if ({pmem_read, i_pmem_resp, pmem_address} !== {1'b0, 1'b0, 16'h0000}) begin
            $display("[TB] FAIL lone_i_release: rd=%b i_resp=%b addr=%h expected idle zeros", pmem_read, i_pmem_resp, pmem_address);
            failures++;
        end
    endtask

    // Serves two simultaneous reads; first_i selects which owner is expected first.
    task automatic run_tie(input string tag, input logic first_i);
        logic [15:0] exp_addr;
        step();
        i_pmem_read    = 1'b1;
        i_pmem_address = 16'h2468;
        d_pmem_read    = 1'b1;
        d_pmem_address = 16'h9ABC;
        for (int g = 0; g < 2; g++) begin
            logic is_i;
            is_i     = (g == 0) ? first_i : ~first_i;
            exp_addr = is_i ? 16'h2460 : 16'h9AB0;
            step();
            #1;
            checks++;
            if ({pmem_read, pmem_address, i_pmem_resp, d_pmem_resp} !== {1'b1, exp_addr, 2'b00}) begin
                $display("[TB] FAIL %s_grant%0d: rd=%b addr=%h resp=%b%b expected rd=1 addr=%h resp=00", tag, g, pmem_read, pmem_address, i_pmem_resp, d_pmem_resp, exp_addr);
                failures++;
            end
            step();
            pmem_resp  = 1'b1;
            pmem_rdata = DATA_5C;
            #1;
            checks++;
            if ({i_pmem_resp, d_pmem_resp} !== {is_i, ~is_i}) begin
                $display("[TB] FAIL %s_resp%0d: i_resp=%b d_resp=%b expected %b %b", tag, g, i_pmem_resp, d_pmem_resp, is_i, ~is_i);
                failures++;
            end
            checks++;
            if ((is_i ? i_pmem_rdata : d_pmem_rdata) !== DATA_5C || (is_i ? d_pmem_rdata : i_pmem_rdata) !== '0) begin
                $display("[TB] FAIL %s_rdata%0d: i_rdata=%h d_rdata=%h owner expected 5c..", tag, g, i_pmem_rdata, d_pmem_rdata);
                failures++;
            end
            step();
            pmem_resp  = 1'b0;
            pmem_rdata = '0;
            if (is_i) i_pmem_read = 1'b0;
            else      d_pmem_read = 1'b0;
            #1;
            checks++;
            if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0000) begin
                $display("[TB] FAIL %s_gap%0d: ctrl=%b expected idle 0000", tag, g, {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp});
                failures++;
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        run_tie("tie1", 1'b0);
        step();
        run_tie("tie2", 1'b0);
    endtask

    // After a lone D grant, round-robin hands the next tie to I; fixed priority keeps D.
    task automatic test_rr_pointer();
        do_reset();
        step();
        d_pmem_read    = 1'b1;
        d_pmem_address = 16'h0040;
        step();
        step();
        pmem_resp = 1'b1;
        step();
        clear_inputs();
`ifdef MEM_ARBITER_RR_EN
        run_tie("rr", 1'b1);
`else
        run_tie("rr", 1'b0);
`endif
    endtask

    task automatic test_writeback();
        do_reset();
        step();
        d_pmem_write   = 1'b1;
        d_pmem_address = 16'h80F2;
        d_pmem_wdata   = DATA_WB;
        step();
        #1;
        checks++;
        if ({pmem_write, pmem_read, pmem_address} !== {1'b1, 1'b0, 16'h80F0} || pmem_wdata !== DATA_WB) begin
            $display("[TB] FAIL wb_grant: wr=%b rd=%b addr=%h wdata=%h expected wr=1 rd=0 addr=80f0", pmem_write, pmem_read, pmem_address, pmem_wdata);
            failures++;
        end
        step();
        d_pmem_read = 1'b1;
        #1;
        checks++;
        if ({pmem_write, pmem_read} !== 2'b10) begin
            $display("[TB] FAIL wb_both: wr=%b rd=%b expected wr=1 rd=0", pmem_write, pmem_read);
            failures++;
        end
        step();
        pmem_resp = 1'b1;
        #1;
        checks++;
        if ({d_pmem_resp, i_pmem_resp} !== 2'b10) begin
            $display("[TB] FAIL wb_resp: d_resp=%b i_resp=%b expected 1 0", d_pmem_resp, i_pmem_resp);
            failures++;
        end
        step();
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        step();
        d_pmem_read    = 1'b1;
        d_pmem_address = 16'h3330;
        step();
        reset = 1'b1;
        step();
        reset       = 1'b0;
        d_pmem_read = 1'b0;
        #1;
        checks++;
        if ({pmem_read, pmem_write, d_pmem_resp, pmem_address} !== {3'b000, 16'h0000}) begin
            $display("[TB] FAIL reset_mid_idle: rd=%b wr=%b d_resp=%b addr=%h expected zeros", pmem_read, pmem_write, d_pmem_resp, pmem_address);
            failures++;
        end
        step();
        pmem_resp = 1'b1;
        #1;
        checks++;
        if ({d_pmem_resp, i_pmem_resp, pmem_read} !== 3'b000) begin
            $display("[TB] FAIL reset_mid_late_resp: d_resp=%b i_resp=%b rd=%b expected 000", d_pmem_resp, i_pmem_resp, pmem_read);
            failures++;
        end
        step();
        clear_inputs();
    endtask

    task automatic test_idle_resp();
        do_reset();
        step();
        pmem_resp  = 1'b1;
        pmem_rdata = DATA_A5;
        #1;
        checks++;
        if ({i_pmem_resp, d_pmem_resp} !== 2'b00 || i_pmem_rdata !== '0 || d_pmem_rdata !== '0) begin
            $display("[TB] FAIL idle_resp: i_resp=%b d_resp=%b expected 00 and zero rdata", i_pmem_resp, d_pmem_resp);
            failures++;
        end
        step();
        pmem_resp = 1'b0;
        #1;
        checks++;
        if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0000) begin
            $display("[TB] FAIL idle_stays: ctrl=%b expected 0000", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp});
            failures++;
        end
    endtask

    task automatic test_withdraw();
        do_reset();
        step();
        i_pmem_read    = 1'b1;
        i_pmem_address = 16'h7770;
        step();
        step();
        i_pmem_read = 1'b0;
        #1;
        checks++;
        if (pmem_read !== 1'b0) begin
            $display("[TB] FAIL withdraw_rd: pmem_read=%b expected 0", pmem_read);
            failures++;
        end
        step();
        pmem_resp = 1'b1;
        #1;
        checks++;
        if ({i_pmem_resp, d_pmem_resp, pmem_address} !== {2'b00, 16'h0000}) begin
            $display("[TB] FAIL withdraw_resp: i_resp=%b d_resp=%b addr=%h expected idle", i_pmem_resp, d_pmem_resp, pmem_address);
            failures++;
        end
        step();
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_lone_i();
        test_back_to_back();
        test_rr_pointer();
        test_writeback();
        test_reset_mid();
        test_idle_resp();
        test_withdraw();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
